ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 TIMEOUT_CYCLES, 255, cycles in REQ without MEM_R before abort (8-bit; used only with IFETCH_TIMEOUT_EN).
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RESET_N  in  1  asynchronous, active-low reset.
REQ-004 START  in  1  fetch request from control; sampled only in IDLE.
REQ-005 FLUSH  in  1  abort in-flight fetch (redirect/branch).
REQ-006 PC  in  16  current PC value from PC block.
REQ-007 MEM_EN  out  1  memory read request, level.
REQ-008 MEM_ADDR  out  16  word-aligned fetch address.
REQ-009 MEM_RDATA  in  16  memory read data, valid when MEM_R=1.
REQ-010 MEM_R  in  1  memory ready/data-valid.
REQ-011 IR  out  16  instruction register.
REQ-012 IR_VALID  out  1  one-cycle pulse: IR holds new instruction.
REQ-013 LD_PC  out  1  one-cycle pulse to PC block to advance PC.
REQ-014 PCMUX  out  2  PC select; always 2'b00 (PC+2) when LD_PC=1, else 2'b00.
REQ-015 BUSY  out  1  high in any state other than IDLE.
REQ-016 FETCH_CNT  out  16  count of completed fetches.
REQ-017 FETCH_ERR  out  1  one-cycle pulse on timeout abort.

Function
REQ-018 FSM states SHALL be IDLE, REQ, LDIR.
REQ-019 IDLE: START=1 and FLUSH=0 -> MAR<=PC, go REQ; else stay IDLE.
REQ-020 MEM_ADDR SHALL equal {MAR[15:1],1'b0}; odd PC is silently aligned.
REQ-021 REQ: MEM_EN=1; MEM_R=1 and FLUSH=0 -> IR<=MEM_RDATA, go LDIR; MEM_R=0 -> stay REQ.
REQ-022 LDIR: IR_VALID=1, LD_PC=1, FETCH_CNT increments by 1 (wraps 16'hFFFF->0), go IDLE unconditionally.
REQ-023 Minimum latency: START sampled at edge N, MEM_EN high cycle N+1, MEM_R=1 in N+1 -> IR_VALID/LD_PC high cycle N+2, BUSY low cycle N+3.
REQ-024 START while BUSY=1 SHALL be ignored (not queued).
REQ-025 FLUSH in REQ (incl. same cycle as MEM_R) SHALL win: IR unchanged, go IDLE, MEM_EN low next cycle.
REQ-026 FLUSH in LDIR SHALL gate IR_VALID, LD_PC and FETCH_CNT increment low that cycle; IR keeps loaded value; go IDLE.
REQ-027 FLUSH and START together in IDLE: FLUSH wins, stay IDLE.
REQ-028 MAR SHALL not change outside the IDLE->REQ transition.

Reset
REQ-029 RESET_N low SHALL immediately force state IDLE, MAR=0, IR=0, FETCH_CNT=0, timer=0, all outputs 0.
REQ-030 Reset mid-REQ SHALL drop MEM_EN asynchronously; no IR_VALID/LD_PC follows.

Configuration
REQ-031 Macro IFETCH_TIMEOUT_EN defined: 8-bit timer clears on entry to REQ, increments each REQ cycle with MEM_R=0; at TIMEOUT_CYCLES -> FETCH_ERR pulse, go IDLE, IR unchanged, FETCH_CNT unchanged.
REQ-032 MEM_R=1 in the same cycle the timer reaches TIMEOUT_CYCLES SHALL complete normally (no error).
REQ-033 Macro undefined: no timer logic, FETCH_ERR tied 0, REQ waits indefinitely.

Structure
REQ-034 Shared package lc3b_pkg SHALL hold FSM state encodings and PCMUX constants (PCMUX_PLUS2=2'b00, PCMUX_BUS=2'b01, PCMUX_ADDR=2'b10).
REQ-035 Timeout counter SHALL be sub-module ifetch_timer, instantiated only under IFETCH_TIMEOUT_EN.

Verification
REQ-036 PC=16'h3000, START pulse, MEM_R=1 first REQ cycle, MEM_RDATA=16'h1234 -> MEM_ADDR=16'h3000, IR=16'h1234, IR_VALID/LD_PC one cycle at N+2, PCMUX=00, FETCH_CNT=1.
REQ-037 PC=16'h3001, MEM_R delayed 4 cycles -> MEM_ADDR=16'h3000 held 5 cycles, START pulses during BUSY ignored, single IR_VALID.
REQ-038 FLUSH with MEM_R=1 in REQ, MEM_RDATA=16'hBEEF -> IR unchanged, no IR_VALID/LD_PC, BUSY low next cycle.
REQ-039 FETCH_CNT preset via 65535 fetches, one more -> FETCH_CNT=0; RESET_N low mid-REQ -> MEM_EN=0 immediately, IR=0.
REQ-040 IFETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, MEM_R held 0 -> FETCH_ERR single pulse after 4 REQ cycles, IDLE; MEM_R=1 on 4th cycle -> normal completion, FETCH_ERR=0.

Source files
------------

// File: rtl/lc3b_pkg.sv
// Shared LC-3b fetch definitions: FSM state encodings and PC-mux selects.
// Imported by the ifetch top and its timeout timer.
package lc3b_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_LDIR = 2'b10
    } fetch_state_t;

    localparam logic [1:0] PCMUX_PLUS2 = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDR  = 2'b10;

    localparam int unsigned TIMER_W = 8;

endpackage

// File: rtl/ifetch_timer.sv
// REQ-phase watchdog: counts waiting cycles, flags expiry on the cycle the count would reach LIMIT.
// Latency: expire is combinational on inc; no backpressure (pure counter).
import lc3b_pkg::*;

module ifetch_timer #(
    parameter logic [TIMER_W-1:0] LIMIT = 8'd255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    logic [TIMER_W-1:0] cnt;

    // Fires in the cycle whose increment would land on LIMIT, so the abort
    // happens after exactly LIMIT waiting cycles.
    assign expire = inc && ((cnt + 8'd1) == LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch FSM (IDLE -> REQ -> LDIR): one memory read per START, IR load and PC advance.
// Latency: START at edge N -> MEM_EN cycle N+1 -> IR_VALID/LD_PC cycle N+2; REQ waits on MEM_R.
// Optional abort of a stalled REQ when IFETCH_TIMEOUT_EN is defined.
import lc3b_pkg::*;

module ifetch #(
    parameter logic [TIMER_W-1:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        flush,
    input  logic [15:0] pc,
    output logic        mem_en,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_r,
    output logic [15:0] ir,
    output logic        ir_valid,
    output logic        ld_pc,
    output logic [1:0]  pcmux,
    output logic        busy,
    output logic [15:0] fetch_cnt,
    output logic        fetch_err
);

    fetch_state_t state;
    logic [14:0]  mar;
    logic         launch;
    logic         commit;
    logic         timeout;
    logic         unused_ok;

    assign launch   = (state == ST_IDLE) && start && !flush;
    // Flush in LDIR suppresses the handoff in the same cycle.
    assign commit   = (state == ST_LDIR) && !flush;

    assign mem_addr = {mar, 1'b0};
    assign ir_valid = commit;
    assign ld_pc    = commit;
    assign pcmux    = PCMUX_PLUS2;

`ifdef IFETCH_TIMEOUT_EN
    logic timer_inc;

    assign timer_inc = (state == ST_REQ) && !mem_r && !flush;

    ifetch_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (launch),
        .inc     (timer_inc),
        .expire  (timeout)
    );

    assign unused_ok = ^{pc[0], PCMUX_BUS, PCMUX_ADDR};
`else
    assign timeout   = 1'b0;
    assign unused_ok = ^{pc[0], PCMUX_BUS, PCMUX_ADDR, TIMEOUT_CYCLES};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            mar       <= '0;
            ir        <= '0;
            fetch_cnt <= '0;
            mem_en    <= 1'b0;
            busy      <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            fetch_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        mar    <= pc[15:1];
                        state  <= ST_REQ;
                        mem_en <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // Flush beats data; data beats the timeout in the same cycle.
                    if (flush) begin
                        state  <= ST_IDLE;
                        mem_en <= 1'b0;
                        busy   <= 1'b0;
                    end else if (mem_r) begin
                        ir     <= mem_rdata;
                        state  <= ST_LDIR;
                        mem_en <= 1'b0;
                    end else if (timeout) begin
                        state     <= ST_IDLE;
                        mem_en    <= 1'b0;
                        busy      <= 1'b0;
                        fetch_err <= 1'b1;
                    end
                end
                ST_LDIR: begin
                    if (commit) begin
                        fetch_cnt <= fetch_cnt + 16'd1;
                    end
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    mem_en <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: hand-computed vectors checked with immediate assertions.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        flush;
    logic [15:0] pc;
    logic [15:0] mem_rdata;
    logic        mem_r;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic [15:0] ir;
    logic        ir_valid;
    logic        ld_pc;
    logic [1:0]  pcmux;
    logic        busy;
    logic [15:0] fetch_cnt;
    logic        fetch_err;

    int vectors     = 0;
    int miscompares = 0;

    ifetch #(.TIMEOUT_CYCLES(8'd4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .flush     (flush),
        .pc        (pc),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_r     (mem_r),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .ld_pc     (ld_pc),
        .pcmux     (pcmux),
        .busy      (busy),
        .fetch_cnt (fetch_cnt),
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Back-to-back single fetch with MEM_R ready in the first REQ cycle.
    task automatic do_fetch(input logic [15:0] a, input logic [15:0] d);
        pc = a; start = 1'b1; mem_r = 1'b1; mem_rdata = d;
        step();
        start = 1'b0;
        step();
        mem_r = 1'b0;
        step();
    endtask

    initial begin
        logic bad;
        reset_n = 1'b0; start = 1'b0; flush = 1'b0; pc = '0; mem_rdata = '0; mem_r = 1'b0;
        #3;
        chk("rst_mem_en",    {15'd0, mem_en},    16'd0);
        chk("rst_busy",      {15'd0, busy},      16'd0);
        chk("rst_ir",        ir,                 16'h0000);
        chk("rst_fetch_cnt", fetch_cnt,          16'h0000);
        chk("rst_ir_valid",  {15'd0, ir_valid},  16'd0);
        chk("rst_fetch_err", {15'd0, fetch_err}, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Basic fetch at 0x3000, minimum latency
        pc = 16'h3000; start = 1'b1; mem_r = 1'b1; mem_rdata = 16'h1234;
        step();
        start = 1'b0;
        chk("t1_mem_en",   {15'd0, mem_en},   16'd1);
        chk("t1_mem_addr", mem_addr,          16'h3000);
        chk("t1_busy",     {15'd0, busy},     16'd1);
        chk("t1_irv_early",{15'd0, ir_valid}, 16'd0);
        step();
        mem_r = 1'b0;
        chk("t1_ir",       ir,                16'h1234);
        chk("t1_ir_valid", {15'd0, ir_valid}, 16'd1);
        chk("t1_ld_pc",    {15'd0, ld_pc},    16'd1);
        chk("t1_pcmux",    {14'd0, pcmux},    16'd0);
        chk("t1_mem_en_lo",{15'd0, mem_en},   16'd0);
        step();
        chk("t1_irv_pulse",{15'd0, ir_valid}, 16'd0);
        chk("t1_busy_lo",  {15'd0, busy},     16'd0);
        chk("t1_cnt",      fetch_cnt,         16'd1);

        // Odd PC, MEM_R delayed 4 cycles, START re-pulsed while busy
        pc = 16'h3001; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_mem_en",   {15'd0, mem_en},   16'd1);
            chk("t2_mem_addr", mem_addr,          16'h3000);
            chk("t2_irv_wait", {15'd0, ir_valid}, 16'd0);
            start = i[0];
            pc    = 16'h5000;
            if (i == 4) begin
                mem_r = 1'b1; mem_rdata = 16'h5678;
            end
            step();
        end
        chk("t2_ir",       ir,                16'h5678);
        chk("t2_ir_valid", {15'd0, ir_valid}, 16'd1);
        start = 1'b0; mem_r = 1'b0;
        step();
        chk("t2_busy_lo",  {15'd0, busy},     16'd0);
        chk("t2_cnt",      fetch_cnt,         16'd2);
        step();
        chk("t2_no_refetch", {15'd0, busy},   16'd0);
        chk("t2_no_irv",   {15'd0, ir_valid}, 16'd0);

        // FLUSH in REQ together with MEM_R
        pc = 16'h4000; start = 1'b1;
        step();
        start = 1'b0; mem_r = 1'b1; mem_rdata = 16'hBEEF; flush = 1'b1;
        chk("t3_mem_en",   {15'd0, mem_en},   16'd1);
        step();
        flush = 1'b0; mem_r = 1'b0;
        chk("t3_ir_kept",  ir,                16'h5678);
        chk("t3_no_irv",   {15'd0, ir_valid}, 16'd0);
        chk("t3_no_ldpc",  {15'd0, ld_pc},    16'd0);
        chk("t3_busy_lo",  {15'd0, busy},     16'd0);
        chk("t3_mem_en_lo",{15'd0, mem_en},   16'd0);
        chk("t3_cnt",      fetch_cnt,         16'd2);

        // FLUSH and START together in IDLE
        start = 1'b1; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0;
        chk("t4_idle_busy",  {15'd0, busy},   16'd0);
        chk("t4_idle_memen", {15'd0, mem_en}, 16'd0);

        // FLUSH in LDIR gates the handoff
        pc = 16'h0010; start = 1'b1; mem_r = 1'b1; mem_rdata = 16'h9ABC;
        step();
        start = 1'b0;
        step();
        mem_r = 1'b0; flush = 1'b1;
        #1;
        chk("t5_irv_gated",  {15'd0, ir_valid}, 16'd0);
        chk("t5_ldpc_gated", {15'd0, ld_pc},    16'd0);
        chk("t5_ir_loaded",  ir,                16'h9ABC);
        step();
        flush = 1'b0;
        chk("t5_cnt",        fetch_cnt,         16'd2);
        chk("t5_busy_lo",    {15'd0, busy},     16'd0);

        // Fetch counter wrap: preset near the top, then two fetches
        force dut.fetch_cnt = 16'hFFFE;
        #1;
        release dut.fetch_cnt;
        #1;
        do_fetch(16'h2000, 16'h1111);
        chk("t6_cnt_ffff", fetch_cnt, 16'hFFFF);
        do_fetch(16'h2002, 16'h2222);
        chk("t6_cnt_wrap", fetch_cnt, 16'h0000);
        chk("t6_ir",       ir,        16'h2222);

        // Asynchronous reset in the middle of REQ
        pc = 16'h3100; start = 1'b1;
        step();
        start = 1'b0;
        chk("t7_mem_en",     {15'd0, mem_en},   16'd1);
        #2;
        reset_n = 1'b0; mem_r = 1'b1; mem_rdata = 16'h7E7E;
        #1;
        chk("t7_async_memen",{15'd0, mem_en},   16'd0);
        chk("t7_async_ir",   ir,                16'h0000);
        chk("t7_async_busy", {15'd0, busy},     16'd0);
        chk("t7_async_irv",  {15'd0, ir_valid}, 16'd0);
        @(negedge clk);
        reset_n = 1'b1; mem_r = 1'b0;
        step();
        chk("t7_post_irv",   {15'd0, ir_valid}, 16'd0);
        chk("t7_post_ldpc",  {15'd0, ld_pc},    16'd0);
        chk("t7_post_busy",  {15'd0, busy},     16'd0);

`ifdef IFETCH_TIMEOUT_EN
        // Timeout with TIMEOUT_CYCLES=4
        pc = 16'h6000; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t8_wait_memen", {15'd0, mem_en},    16'd1);
            chk("t8_wait_err",   {15'd0, fetch_err}, 16'd0);
            step();
        end
        chk("t8_err",       {15'd0, fetch_err}, 16'd1);
        chk("t8_busy_lo",   {15'd0, busy},      16'd0);
        chk("t8_ir_kept",   ir,                 16'h0000);
        chk("t8_cnt_kept",  fetch_cnt,          16'h0000);
        chk("t8_no_irv",    {15'd0, ir_valid},  16'd0);
        step();
        chk("t8_err_pulse", {15'd0, fetch_err}, 16'd0);

        // MEM_R on the 4th REQ cycle completes normally
        pc = 16'h6002; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        mem_r = 1'b1; mem_rdata = 16'h7777;
        chk("t9_still_req", {15'd0, mem_en},    16'd1);
        step();
        mem_r = 1'b0;
        chk("t9_ir_valid",  {15'd0, ir_valid},  16'd1);
        chk("t9_ir",        ir,                 16'h7777);
        chk("t9_no_err",    {15'd0, fetch_err}, 16'd0);
        step();
        chk("t9_no_err2",   {15'd0, fetch_err}, 16'd0);
        chk("t9_cnt",       fetch_cnt,          16'd1);
`else
        // Without the timeout, REQ waits indefinitely
        pc = 16'h6000; start = 1'b1;
        step();
        start = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (fetch_err !== 1'b0 || mem_en !== 1'b1) bad = 1'b1;
            step();
        end
        chk("t8_long_wait", {15'd0, bad},       16'd0);
        chk("t8_no_err",    {15'd0, fetch_err}, 16'd0);
        mem_r = 1'b1; mem_rdata = 16'h4321;
        step();
        mem_r = 1'b0;
        chk("t8_ir_valid",  {15'd0, ir_valid},  16'd1);
        chk("t8_ir",        ir,                 16'h4321);
        step();
        chk("t8_cnt",       fetch_cnt,          16'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
